// File: rtl/jk_pkg.sv
// Shared JK excitation codes and the next-count rule used by the JK modulo counter.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Returns {J,K}; toggle is never produced so every transition is explicit.
   function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
      logic [1:0] jk;
      jk = JK_HOLD;
      if (!q && q_next) begin
         jk = JK_SET;
      end else if (q && !q_next) begin
         jk = JK_RST;
      end
      return jk;
   endfunction

   // Out-of-range states fall to 0 (up) or modulus-1 (down) to self-recover.
   function automatic int unsigned next_count(input int unsigned q, input logic up,
                                              input int unsigned modulus);
      int unsigned nxt;
      if (up) begin
         nxt = (q >= modulus - 1) ? 0 : q + 1;
      end else begin
         nxt = (q == 0 || q >= modulus) ? modulus - 1 : q - 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic J,
   input  logic K,
   output logic Q
);

   logic r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= 1'b0;
      end else begin
         unique case ({J, K})
            JK_HOLD: r_q <= r_q;
            JK_RST:  r_q <= 1'b0;
            JK_SET:  r_q <= 1'b1;
            JK_TGL:  r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign Q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built on JK cells; this level only forms Q_next, the J/K
// excitation and the terminal count.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               EN,
   input  logic               UP,
   input  logic               LOAD,
   input  logic [WIDTH-1:0]   D,
   output logic [WIDTH-1:0]   Q,
   output logic               TC,
   output logic [2*WIDTH-1:0] JK_OUT
);

   // Compares use WIDTH+1 bits so MODULUS == 2**WIDTH does not wrap.
   localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH:0]   w_d_ext;
   logic [WIDTH:0]   w_q_ext;

   assign w_d_ext = {1'b0, D};
   assign w_q_ext = {1'b0, w_q};

   always_comb begin
      w_next = w_q;
      if (LOAD) begin
         w_next = (w_d_ext < LP_MOD) ? D : LP_MAX;
      end else if (EN) begin
         w_next = WIDTH'(next_count(32'(w_q_ext), UP, MODULUS));
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign {w_j[i], w_k[i]} = jk_excite(w_q[i], w_next[i]);

      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .J     (w_j[i]),
         .K     (w_k[i]),
         .Q     (w_q[i])
      );
   end

   assign Q      = w_q;
   assign JK_OUT = {w_j, w_k};
   assign TC     = EN & ~LOAD & ((UP & (w_q == LP_MAX)) | (~UP & (w_q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: arithmetic reference model checked every cycle on two builds
// (MODULUS=10 and MODULUS=16) plus directed literal expectations.
module tb_jk_mod_counter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic [3:0] q10;
   logic [3:0] q16;
   logic       tc10;
   logic       tc16;
   logic [7:0] jk10;
   logic [7:0] jk16;

   int errs;
   int checks;
   int mq10;
   int mq16;
   bit run_cmp;

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
      .clk    (clk),
      .rst_n  (rst_n),
      .EN     (en),
      .UP     (up),
      .LOAD   (load),
      .D      (d),
      .Q      (q10),
      .TC     (tc10),
      .JK_OUT (jk10)
   );

   jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
      .clk    (clk),
      .rst_n  (rst_n),
      .EN     (en),
      .UP     (up),
      .LOAD   (load),
      .D      (d),
      .Q      (q16),
      .TC     (tc16),
      .JK_OUT (jk16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_next(int q, int m, bit ld, bit e, bit u, int dv);
      if (ld) return (dv < m) ? dv : m - 1;
      if (!e) return q;
      if (u) return (q >= m - 1) ? 0 : q + 1;
      return (q == 0 || q >= m) ? m - 1 : q - 1;
   endfunction

   function automatic bit model_tc(int q, int m, bit ld, bit e, bit u);
      return e && !ld && ((u && q == m - 1) || (!u && q == 0));
   endfunction

   // Set where a bit rises, reset where it falls, nothing otherwise; packed {J,K}.
   function automatic logic [7:0] model_jk(int q, int nxt);
      logic [3:0] j;
      logic [3:0] k;
      for (int b = 0; b < 4; b++) begin
         j[b] = (((q >> b) & 1) == 0) && (((nxt >> b) & 1) == 1);
         k[b] = (((q >> b) & 1) == 1) && (((nxt >> b) & 1) == 0);
      end
      return {j, k};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq10 <= 0;
         mq16 <= 0;
      end else begin
         mq10 <= model_next(mq10, 10, load, en, up, int'(d));
         mq16 <= model_next(mq16, 16, load, en, up, int'(d));
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         check("cmp_q10", 32'(q10), 32'(mq10));
         check("cmp_tc10", 32'(tc10), 32'(model_tc(mq10, 10, load, en, up)));
         check("cmp_jk10", 32'(jk10),
               32'(model_jk(mq10, model_next(mq10, 10, load, en, up, int'(d)))));
         check("cmp_q16", 32'(q16), 32'(mq16));
         check("cmp_tc16", 32'(tc16), 32'(model_tc(mq16, 16, load, en, up)));
         check("cmp_jk16", 32'(jk16),
               32'(model_jk(mq16, model_next(mq16, 16, load, en, up, int'(d)))));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errs    = 0;
      checks  = 0;
      run_cmp = 1'b0;
      rst_n   = 1'b0;
      en      = 1'b0;
      up      = 1'b1;
      load    = 1'b0;
      d       = 4'd0;
      #1 run_cmp = 1'b1;
      #11;
      rst_n = 1'b1;
      en    = 1'b1;
      up    = 1'b1;
      #1;
      check("reset_q", 32'(q10), 32'd0);
      check("reset_tc", 32'(tc10), 32'd0);

      // Up count 0..9 then wrap; TC only at 9, and 9->0 clears bits 3 and 0.
      for (int i = 1; i <= 12; i++) begin
         tick();
         check("up_q", 32'(q10), 32'(i % 10));
         check("up_tc", 32'(tc10), 32'((i % 10) == 9));
         if (i == 9) check("up_jk_9to0", 32'(jk10), 32'h09);
      end
      check("up16_q", 32'(q16), 32'd12);

      // Async reset, then count down with wrap through 9.
      rst_n = 1'b0;
      #2;
      check("rst_q", 32'(q10), 32'd0);
      rst_n = 1'b1;
      up    = 1'b0;
      #1;
      check("down_tc_at0", 32'(tc10), 32'd1);
      tick();
      check("down_q9", 32'(q10), 32'd9);
      check("down16_q15", 32'(q16), 32'd15);
      tick();
      check("down_q8", 32'(q10), 32'd8);
      tick();
      check("down_q7", 32'(q10), 32'd7);

      // Loads: plain, saturated, and load winning over enable.
      en   = 1'b0;
      load = 1'b1;
      d    = 4'd7;
      tick();
      check("load7", 32'(q10), 32'd7);
      d = 4'd12;
      tick();
      check("load12_sat", 32'(q10), 32'd9);
      check("load12_m16", 32'(q16), 32'd12);
      en = 1'b1;
      up = 1'b1;
      d  = 4'd3;
      #1;
      check("load_en_tc", 32'(tc10), 32'd0);
      tick();
      check("load_en_q", 32'(q10), 32'd3);

      // Hold at 5.
      en   = 1'b0;
      d    = 4'd5;
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_q", 32'(q10), 32'd5);
         check("hold_jk", 32'(jk10), 32'd0);
         check("hold_tc", 32'(tc10), 32'd0);
      end

      // Reset pulse 2 ns after the edge that reaches 6.
      en = 1'b1;
      up = 1'b1;
      tick();
      check("pre_rst_q6", 32'(q10), 32'd6);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_q", 32'(q10), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_q1", 32'(q10), 32'd1);
      tick();
      check("post_rst_q2", 32'(q10), 32'd2);

      // Direction flip at 4.
      tick();
      tick();
      check("flip_q4", 32'(q10), 32'd4);
      up = 1'b0;
      tick();
      check("flip_q3", 32'(q10), 32'd3);
      tick();
      check("flip_q2", 32'(q10), 32'd2);

      // Full-range build wraps 15 -> 0.
      up   = 1'b1;
      load = 1'b1;
      d    = 4'd14;
      tick();
      load = 1'b0;
      check("m16_q14", 32'(q16), 32'd14);
      tick();
      check("m16_q15", 32'(q16), 32'd15);
      check("m16_tc15", 32'(tc16), 32'd1);
      tick();
      check("m16_wrap0", 32'(q16), 32'd0);
      tick();
      #5;

      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
Synchronous modulo-N up/down counter whose state register is a bank of JK flip-flop cells. The block computes the J/K excitation for every bit from the present state and the control inputs, so it is the stage that drives the J/K inputs of the flip-flops. It is the counting datapath of Project 2 and feeds the display/decoder stage through Q and TC.

Parameters:
WIDTH, 4, counter width in bits; must satisfy 2**WIDTH >= MODULUS.
MODULUS, 10, count range is 0..MODULUS-1; legal values are 2..2**WIDTH.

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
rst_n  input  1  asynchronous, active-low reset.
EN  input  1  count enable.
UP  input  1  direction: 1 counts up, 0 counts down.
LOAD  input  1  synchronous parallel load; has priority over EN.
D  input  WIDTH  parallel load value.
Q  output  WIDTH  present count, taken directly from the JK cell outputs.
TC  output  1  terminal count, combinational.
JK_OUT  output  2*WIDTH  debug view of the excitation, packed as {J[WIDTH-1:0], K[WIDTH-1:0]}.

Behaviour:
- Reset: rst_n=0 forces Q=0 immediately, independent of clk. TC and JK_OUT follow combinationally from Q=0 and the inputs. Counting resumes on the first rising clk edge after rst_n is released.
- Next-state priority on each rising edge:
  - LOAD=1: Q_next = D if D < MODULUS, otherwise MODULUS-1 (saturated).
  - LOAD=0, EN=1, UP=1: Q_next = (Q == MODULUS-1) ? 0 : Q+1.
  - LOAD=0, EN=1, UP=0: Q_next = (Q == 0) ? MODULUS-1 : Q-1.
  - Otherwise: Q_next = Q (hold).
- Excitation, per bit i, derived from (Q[i], Q_next[i]):
  - 0->0 gives J=0, K=0 (hold).
  - 0->1 gives J=1, K=0 (set).
  - 1->0 gives J=0, K=1 (reset).
  - 1->1 gives J=0, K=0 (hold).
  - J=K=1 (toggle) is never produced. This makes the excitation deterministic and checkable.
- JK cell: on a rising edge, J/K = 00 holds, 01 resets, 10 sets, 11 toggles. Async reset to 0.
- Latency: Q updates one clk edge after the inputs are sampled. No internal pipelining.
- TC = EN & ~LOAD & ((UP & Q == MODULUS-1) | (~UP & Q == 0)). It is asserted during the cycle before the wrap edge.
- Out-of-range state: Q >= MODULUS can only arise from an illegal parameter setting or a fault. In that case counting up gives Q_next=0 and counting down gives Q_next=MODULUS-1, so the counter self-recovers in one enabled edge.
- Simultaneous LOAD and EN: the load wins and TC=0.
- Direction change mid-count takes effect on the next edge with no dead cycle.
- Reset asserted mid-count clears Q at once. When reset is released, no stale excitation is applied; the next edge uses Q=0.
- All arithmetic is done in WIDTH+1 bits to avoid wrap when comparing against MODULUS=2**WIDTH.

Decomposition:
- Package jk_pkg:
  - localparams JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - function jk_excite(q, q_next) returning {J,K}.
  - function next_count(q, up, modulus).
- One sub-module, jk_cell (ports clk, rst_n, J, K, Q), instantiated WIDTH times in a generate loop.
- The top level holds only the next-state and excitation logic plus the TC logic.

Test Plan:
- Reset then count up: rst_n=0 for 12 ns, then EN=1, UP=1 for 12 clocks -> Q = 0,1,...,9,0,1. TC=1 only while Q=9. JK_OUT for the 9->0 transition = J=0000, K=1001.
- Count down and wrap: after reset, EN=1, UP=0 -> Q = 9,8,7... TC=1 on the cycle where Q=0, before the first edge.
- Load: LOAD=1, D=7 -> Q=7 after one edge. LOAD=1, D=12 -> Q=9 (saturated). LOAD=1 with EN=1, D=3 -> Q=3 and TC=0.
- Hold: EN=0, LOAD=0 at Q=5 for 5 clocks -> Q stays 5, JK_OUT=0, TC=0.
- Async reset mid-count: rst_n pulled low 2 ns after an edge at Q=6 -> Q=0 within that cycle, before the next edge. After release, counting continues 1,2,...
- Direction flip: at Q=4 switch UP 1->0 -> sequence 4,3,2 with no skipped or repeated value. Also MODULUS=16, WIDTH=4 build: up count gives 15->0 and TC=1 at Q=15.
